// File: rtl/operand_stack_if.sv
// Controller-side bundle for the operand stack: push/pop strobes, push data,
// flag clear, and the registered stack view (tos/nos/count/status flags).
interface operand_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = 4
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din, err_clr,
    input  tos, nos, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din, err_clr,
    output tos, nos, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack with registered TOS/NOS so the ALU sees both operands at once.
// Define OPSTACK_ERR_EN to get sticky overflow/underflow flags with err_clr.
module operand_stack #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 4
) (
  input logic              clk,
  input logic              rst,
  operand_stack_if.slave   bus
);

  typedef enum logic [2:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpReplace,
    OpOverflow,
    OpUnderflow
  } op_e;

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [WIDTH-1:0] entry_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             is_empty, is_full;
  logic [CW-1:0]    top_idx;
  logic [CW-1:0]    third_idx;
  logic [WIDTH-1:0] third_val;
  op_e              op;

  assign is_empty  = (count_q == '0);
  assign is_full   = (count_q == CW'(DEPTH));
  assign top_idx   = count_q - CW'(1);
  assign third_idx = count_q - CW'(3);

  // Empty push+pop degenerates to a plain push; a full push+pop is a legal replace.
  always_comb begin
    op = OpIdle;
    unique case ({bus.push, bus.pop})
      2'b10:   op = is_full  ? OpOverflow  : OpPush;
      2'b01:   op = is_empty ? OpUnderflow : OpPop;
      2'b11:   op = is_empty ? OpPush      : OpReplace;
      default: op = OpIdle;
    endcase
  end

  // Entry that becomes NOS after a pop; only used when the stack holds 3 or more.
  always_comb begin
    third_val = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) == third_idx) third_val = entry_q[i];
    end
  end

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    tos_d   = tos_q;
    nos_d   = nos_q;
    unique case (op)
      OpPush: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_q) entry_d[i] = bus.din;
        end
        count_d = count_q + CW'(1);
        tos_d   = bus.din;
        nos_d   = tos_q;
      end
      OpPop: begin
        count_d = top_idx;
        tos_d   = nos_q;
        nos_d   = (count_q >= CW'(3)) ? third_val : '0;
      end
      OpReplace: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CW'(i) == top_idx) entry_d[i] = bus.din;
        end
        tos_d = bus.din;
      end
      default: ;
    endcase
  end

`ifdef OPSTACK_ERR_EN
  // A new error event in the same cycle as err_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (op == OpOverflow)  ovf_d = 1'b1;
    if (op == OpUnderflow) udf_d = 1'b1;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;

  always_comb begin
    ovf_d = 1'b0;
    udf_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      count_q <= '0;
      tos_q   <= '0;
      nos_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      count_q <= count_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign bus.tos       = tos_q;
  assign bus.nos       = nos_q;
  assign bus.count     = count_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack; flag expectations follow OPSTACK_ERR_EN.
module tb_operand_stack;

`ifdef OPSTACK_ERR_EN
  localparam logic ErrEn = 1'b1;
`else
  localparam logic ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  operand_stack_if #(.WIDTH(8), .CW(4)) b ();

  operand_stack #(.WIDTH(8), .DEPTH(8), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic p, input logic q, input logic [7:0] d, input logic c);
    b.push = p; b.pop = q; b.din = d; b.err_clr = c;
    @(posedge clk); #1;
    b.push = 1'b0; b.pop = 1'b0; b.din = 8'd0; b.err_clr = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 8'd0, 1'b0);   // empty pop, raises underflow when enabled
    step(1'b1, 1'b0, 8'd11, 1'b0);
    step(1'b1, 1'b0, 8'd22, 1'b0);
    step(1'b1, 1'b0, 8'd33, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.underflow} !== {4'd3, 8'd33, 8'd22, ErrEn}) begin
      $display("FAIL pre_reset: got cnt=%0d tos=%0d nos=%0d udf=%0b, need 3/33/22/%0b",
               b.count, b.tos, b.nos, b.underflow, ErrEn);
      n_bad++;
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.empty, b.full, b.overflow, b.underflow} !==
        {4'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL async_reset: got cnt=%0d tos=%0d nos=%0d e=%0b f=%0b o=%0b u=%0b, need 0/0/0/1/0/0/0",
               b.count, b.tos, b.nos, b.empty, b.full, b.overflow, b.underflow);
      n_bad++;
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({b.count, b.empty} !== {4'd0, 1'b1}) begin
      $display("FAIL post_reset: got cnt=%0d empty=%0b, need 0/1", b.count, b.empty);
      n_bad++;
    end
  endtask

  task automatic test_push_pop();
    step(1'b1, 1'b0, 8'd15, 1'b0);
    step(1'b1, 1'b0, 8'd25, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.empty} !== {4'd2, 8'd25, 8'd15, 1'b0}) begin
      $display("FAIL push2: got cnt=%0d tos=%0d nos=%0d e=%0b, need 2/25/15/0",
               b.count, b.tos, b.nos, b.empty);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd1, 8'd15, 8'd0}) begin
      $display("FAIL pop1: got cnt=%0d tos=%0d nos=%0d, need 1/15/0", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.empty} !== {4'd0, 8'd0, 1'b1}) begin
      $display("FAIL pop2: got cnt=%0d tos=%0d e=%0b, need 0/0/1", b.count, b.tos, b.empty);
      n_bad++;
    end
  endtask

  task automatic test_alu_seq();
    step(1'b1, 1'b0, 8'd15, 1'b0);
    step(1'b1, 1'b0, 8'd25, 1'b0);
    step(1'b0, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd40, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd1, 8'd40, 8'd0}) begin
      $display("FAIL alu1: got cnt=%0d tos=%0d nos=%0d, need 1/40/0", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b1, 1'b0, 8'd35, 1'b0);
    step(1'b1, 1'b0, 8'd5, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd3, 8'd5, 8'd35}) begin
      $display("FAIL alu_push3: got cnt=%0d tos=%0d nos=%0d, need 3/5/35", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd2, 8'd35, 8'd40}) begin
      $display("FAIL alu_pop3: got cnt=%0d tos=%0d nos=%0d, need 2/35/40", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b1, 1'b1, 8'd40, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd2, 8'd40, 8'd40}) begin
      $display("FAIL alu2: got cnt=%0d tos=%0d nos=%0d, need 2/40/40", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b0);
    step(1'b1, 1'b1, 8'd0, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos} !== {4'd1, 8'd0, 8'd0}) begin
      $display("FAIL alu3: got cnt=%0d tos=%0d nos=%0d, need 1/0/0", b.count, b.tos, b.nos);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b0);
  endtask

  task automatic test_full();
    for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.full, b.overflow} !== {4'd8, 8'd8, 8'd7, 1'b1, 1'b0}) begin
      $display("FAIL full: got cnt=%0d tos=%0d nos=%0d f=%0b o=%0b, need 8/8/7/1/0",
               b.count, b.tos, b.nos, b.full, b.overflow);
      n_bad++;
    end
    step(1'b1, 1'b0, 8'd99, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.overflow} !== {4'd8, 8'd8, 8'd7, ErrEn}) begin
      $display("FAIL overflow: got cnt=%0d tos=%0d nos=%0d o=%0b, need 8/8/7/%0b",
               b.count, b.tos, b.nos, b.overflow, ErrEn);
      n_bad++;
    end
    step(1'b1, 1'b1, 8'd77, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.full} !== {4'd8, 8'd77, 8'd7, 1'b1}) begin
      $display("FAIL replace_full: got cnt=%0d tos=%0d nos=%0d f=%0b, need 8/77/7/1",
               b.count, b.tos, b.nos, b.full);
      n_bad++;
    end
    // Drain: after pop j the stack holds 1..(8-j), so nos reloads from deeper entries.
    for (int j = 1; j <= 8; j++) begin
      logic [3:0] ec;
      logic [7:0] et, en;
      step(1'b0, 1'b1, 8'd0, 1'b0);
      ec = 4'(8 - j);
      et = 8'(8 - j);
      en = (j <= 6) ? 8'(7 - j) : 8'd0;
      n_cmp++;
      if ({b.count, b.tos, b.nos} !== {ec, et, en}) begin
        $display("FAIL drain%0d: got cnt=%0d tos=%0d nos=%0d, need %0d/%0d/%0d",
                 j, b.count, b.tos, b.nos, ec, et, en);
        n_bad++;
      end
    end
    step(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (b.overflow !== 1'b0) begin
      $display("FAIL ovf_clear: got o=%0b, need 0", b.overflow);
      n_bad++;
    end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'd0, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.underflow} !== {4'd0, 8'd0, ErrEn}) begin
      $display("FAIL underflow: got cnt=%0d tos=%0d u=%0b, need 0/0/%0b",
               b.count, b.tos, b.underflow, ErrEn);
      n_bad++;
    end
    step(1'b0, 1'b0, 8'd0, 1'b0);
    n_cmp++;
    if (b.underflow !== ErrEn) begin
      $display("FAIL udf_sticky: got u=%0b, need %0b", b.underflow, ErrEn);
      n_bad++;
    end
    step(1'b0, 1'b1, 8'd0, 1'b1);
    n_cmp++;
    if (b.underflow !== ErrEn) begin
      $display("FAIL udf_clr_race: got u=%0b, need %0b", b.underflow, ErrEn);
      n_bad++;
    end
    step(1'b0, 1'b0, 8'd0, 1'b1);
    n_cmp++;
    if (b.underflow !== 1'b0) begin
      $display("FAIL udf_clear: got u=%0b, need 0", b.underflow);
      n_bad++;
    end
  endtask

  task automatic test_empty_push_pop();
    step(1'b1, 1'b1, 8'd9, 1'b0);
    n_cmp++;
    if ({b.count, b.tos, b.nos, b.underflow, b.empty} !== {4'd1, 8'd9, 8'd0, 1'b0, 1'b0}) begin
      $display("FAIL empty_pushpop: got cnt=%0d tos=%0d nos=%0d u=%0b e=%0b, need 1/9/0/0/0",
               b.count, b.tos, b.nos, b.underflow, b.empty);
      n_bad++;
    end
  endtask

  initial begin
    b.push = 1'b0; b.pop = 1'b0; b.din = 8'd0; b.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_push_pop();
    test_alu_seq();
    test_full();
    test_underflow();
    test_empty_push_pop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_stack.md
Name: operand_stack

Overview:
Hardware LIFO operand stack for the stack processor. It sits directly downstream of the data memory: a push captures the memory read data (dataout) when the controller executes a push instruction. Pops feed the ALU and the store path, which returns the result to memory. It exposes top-of-stack (TOS) and next-on-stack (NOS) registers so the ALU can read both operands of a binary operation without extra cycles.

Parameters:
WIDTH, 8, data width in bits; matches the memory word.
DEPTH, 8, number of stack entries; must be at least 2.
CW, 4, width of count; must satisfy 2^CW > DEPTH.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
push  in  1  single-cycle push strobe from controller
pop  in  1  single-cycle pop strobe from controller
din  in  WIDTH  push data (memory dataout or ALU result)
tos  out  WIDTH  top entry; 0 when empty
nos  out  WIDTH  second entry; 0 when count < 2
count  out  CW  number of valid entries
empty  out  1  count == 0
full  out  1  count == DEPTH
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of the sticky flags

Behaviour:
- Reset: asynchronous and active-high. Asserting rst at any time, including mid-operation, immediately forces the following values without waiting for clk: count=0, all entries=0, tos=0, nos=0, empty=1, full=0, overflow=0, underflow=0.
- All state updates on the rising edge of clk. The outputs tos, nos, count, empty and full are registered or derived from registers. They show the post-operation state in the cycle after the strobe, so latency is 1 cycle.
- Storage is an entry array indexed by count. The top entry is entry[count-1].
- Push only (push=1, pop=0, not full): entry[count]=din; count+1; tos=din; nos=old tos.
- Pop only (pop=1, push=0, not empty): count-1; tos=old nos; nos=entry[count-3], or 0 if the new count < 2.
- Push and pop together, not empty: replace top. entry[count-1]=din; count unchanged; tos=din; nos unchanged. This is legal even when full.
- Push and pop together, empty: treated as a push of din. No underflow is flagged.
- Push while full (without pop): ignored. Stack is unchanged; overflow is set to 1.
- Pop while empty (without push): ignored. Stack is unchanged; tos=0; underflow is set to 1.
- No wrap-around: count saturates within 0..DEPTH. The pointer never aliases.
- err_clr clears overflow and underflow at the next edge. If err_clr coincides with a new error event, the new event wins and the flag stays 1.
- Binary ALU operation sequence (controller responsibility, for reference):
  - Controller reads tos and nos, then issues pop.
  - On the next cycle it issues push+pop with din = result.
  - Net effect: two operands are consumed and one result is produced.
- Arithmetic: count uses CW-bit unsigned increment and decrement. Data is never modified by the stack.
- Outputs are never X after reset. Entries above count hold stale values, but those values are never driven onto tos or nos.

Optional Feature:
OPSTACK_ERR_EN.
- Defined: overflow and underflow are sticky registers as specified, and err_clr is functional.
- Undefined: overflow and underflow are tied to 0 and err_clr is ignored. Illegal pushes and pops are still ignored, leaving the stack unchanged.
- In both cases the ports remain present.

Test Plan:
1. Assert rst mid-stream after 3 pushes, asynchronously between edges. Required immediately: count=0, empty=1, tos=0, nos=0, flags=0, with no clk edge needed.
2. Push 15, then push 25 -> count=2, tos=25, nos=15. Then pop -> count=1, tos=15, nos=0. Then pop -> empty=1, tos=0.
3. ALU sequence:
   - Push 15, push 25, then pop.
   - Next cycle: push+pop with din=40 -> count=1, tos=40.
   - Push 35, push 5, pop, then push+pop with din=40 -> count=2, tos=40, nos=40.
   - Pop, then push+pop with din=0 -> tos=0, count=1.
4. Push DEPTH=8 values 1..8 -> full=1, tos=8, nos=7. A 9th push of 99 -> tos=8, count=8, overflow=1. Then push+pop with din=77 -> tos=77, count=8.
5. Pop on an empty stack -> count=0, underflow=1.
   - With OPSTACK_ERR_EN: flag stays 1 until err_clr.
   - err_clr together with another empty pop -> underflow stays 1.
   - err_clr alone -> underflow=0.
   - Without OPSTACK_ERR_EN: underflow is always 0.
6. Push+pop together on an empty stack with din=9 -> count=1, tos=9, underflow=0.
